hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, busy cycles for a mult/multu.
REQ-002 SHALL have parameter DIV_CYC, default 10, busy cycles for a div/divu.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-004 SHALL have the following D-stage inputs:
- D_rs_addr input 5, rs register number.
- D_rt_addr input 5, rt register number.
- D_Tuse_rs input 3, cycles until rs is needed.
- D_Tuse_rt input 3, cycles until rt is needed.
- D_is_mdu input 1, D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-005 SHALL have the following E/M-stage inputs:
- E_wa input 5, E write register.
- E_Tnew input 3, E cycles to result.
- M_wa input 5, M write register.
- M_Tnew input 3, M cycles to result.
- E_start_mult input 1, E instruction starts a multiply (one-cycle pulse).
- E_start_div input 1, E instruction starts a divide (one-cycle pulse).
REQ-006 SHALL have the following outputs:
- F_en output 1, PC enable.
- FD_en output 1, F/D register enable.
- DE_clr output 1, D/E register clear (bubble insert).
- stall output 1, any stall active.
- mdu_busy output 1, multiply/divide unit occupied.
- busy_cnt output 4, remaining busy cycles.
- stall_cnt output 32, cumulative stall cycles (see Configuration).

Function
REQ-007 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-008 In IDLE with E_start_div=1, SHALL load busy_cnt=DIV_CYC and go to BUSY on the next edge.
REQ-009 In IDLE with only E_start_mult=1, SHALL load busy_cnt=MULT_CYC and go to BUSY.
REQ-010 When E_start_mult and E_start_div are both 1, SHALL give divide priority.
REQ-011 In BUSY, SHALL decrement busy_cnt each cycle; on busy_cnt==1 it SHALL go to IDLE with busy_cnt=0.
REQ-012 SHALL ignore start pulses arriving in BUSY, leaving the count unchanged.
REQ-013 SHALL drive mdu_busy = (state==BUSY) | E_start_mult | E_start_div, combinationally in the same cycle.
REQ-014 SHALL compute stall_rs = (D_rs_addr!=0) & ((D_rs_addr==E_wa & E_Tnew>D_Tuse_rs) | (D_rs_addr==M_wa & M_Tnew>D_Tuse_rs)).
REQ-015 SHALL compute stall_rt with the same rule applied to D_rt_addr and D_Tuse_rt.
REQ-016 SHALL compute stall_mdu = D_is_mdu & mdu_busy.
REQ-017 SHALL drive stall = stall_rs | stall_rt | stall_mdu, combinationally with zero-cycle latency.
REQ-018 SHALL drive F_en = FD_en = ~stall and DE_clr = stall.
REQ-019 SHALL treat register 0 as never causing a data stall.
REQ-020 SHALL, when the last BUSY cycle (busy_cnt==1) coincides with D_is_mdu, still stall that cycle; the D instruction advances on the following cycle.

Reset
REQ-021 On reset=1 at a clk edge, SHALL enter IDLE with busy_cnt=0 and stall_cnt=0, including mid-BUSY.
REQ-022 While reset is asserted, SHALL keep F_en/FD_en=1, DE_clr=0 and mdu_busy=0 (inputs are treated as don't-care while reset=1).

Configuration
REQ-023 With macro HAZARD_STALL_CNT_EN defined, SHALL increment stall_cnt by 1 each clk edge where stall=1 and reset=0, wrapping from 0xFFFFFFFF to 0.
REQ-024 Without HAZARD_STALL_CNT_EN, SHALL tie stall_cnt to 0 and instantiate no counter register.

Structure
REQ-025 SHALL place the FSM state encoding (IDLE=0, BUSY=1) and the default MULT_CYC/DIV_CYC constants in shared package pipe_pkg.
REQ-026 SHALL implement the FSM plus busy_cnt in sub-module mdu_busy_tracker; hazard comparison logic stays in hazard_ctrl.

Verification
REQ-027 SHALL cover load-use: E_wa=8, E_Tnew=2, D_rs_addr=8, D_Tuse_rs=1 -> stall=1, DE_clr=1, F_en=0 that cycle.
REQ-028 SHALL cover the $0 exemption: E_wa=0, E_Tnew=2, D_rs_addr=0 -> stall=0.
REQ-029 SHALL cover divide occupancy: E_start_div pulse, D_is_mdu=1 held -> stall=1 for 11 cycles (pulse cycle plus 10 BUSY cycles), busy_cnt 10..1 then 0.
REQ-030 SHALL cover simultaneous starts: E_start_mult=E_start_div=1 -> busy_cnt=10 next cycle.
REQ-031 SHALL cover reset mid-operation: reset at busy_cnt=3 -> next cycle IDLE, busy_cnt=0, mdu_busy=0.
REQ-032 SHALL cover the counter with HAZARD_STALL_CNT_EN defined: 7 stall cycles -> stall_cnt=7; without the macro -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared pipeline constants: MDU FSM encoding, default latencies,
//            and the per-source data-hazard helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_BUSY = 1'b1;

  localparam int c_DEF_MULT_CYC = 5;
  localparam int c_DEF_DIV_CYC  = 10;
  localparam int c_BUSY_CNT_W   = 4;

  // A source stalls when a producer still in flight will not have its result
  // ready by the time the D instruction needs it; $0 never waits.
  function automatic logic src_hazard(
    input logic [4:0] addr,
    input logic [2:0] tuse,
    input logic [4:0] e_wa,
    input logic [2:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [2:0] m_tnew
  );
    return (addr != 5'd0) &&
           (((addr == e_wa) && (e_tnew > tuse)) ||
            ((addr == m_wa) && (m_tnew > tuse)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module   : hazard_ctrl_if
// Brief    : D/E/M hazard inputs and stall/MDU status outputs of hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;
  logic [4:0]  D_rs_addr;
  logic [4:0]  D_rt_addr;
  logic [2:0]  D_Tuse_rs;
  logic [2:0]  D_Tuse_rt;
  logic        D_is_mdu;
  logic [4:0]  E_wa;
  logic [2:0]  E_Tnew;
  logic [4:0]  M_wa;
  logic [2:0]  M_Tnew;
  logic        E_start_mult;
  logic        E_start_div;
  logic        F_en;
  logic        FD_en;
  logic        DE_clr;
  logic        stall;
  logic        mdu_busy;
  logic [3:0]  busy_cnt;
  logic [31:0] stall_cnt;

  modport slave (
    input  D_rs_addr, D_rt_addr, D_Tuse_rs, D_Tuse_rt, D_is_mdu,
    input  E_wa, E_Tnew, M_wa, M_Tnew, E_start_mult, E_start_div,
    output F_en, FD_en, DE_clr, stall, mdu_busy, busy_cnt, stall_cnt
  );

  modport master (
    output D_rs_addr, D_rt_addr, D_Tuse_rs, D_Tuse_rt, D_is_mdu,
    output E_wa, E_Tnew, M_wa, M_Tnew, E_start_mult, E_start_div,
    input  F_en, FD_en, DE_clr, stall, mdu_busy, busy_cnt, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_mdu_busy_tracker.sv
// ============================================================================
// Module   : mdu_busy_tracker
// Brief    : IDLE/BUSY occupancy FSM and remaining-cycle counter of the MDU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_busy_tracker
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = c_DEF_MULT_CYC,
  parameter int DIV_CYC  = c_DEF_DIV_CYC
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  input  wire logic                    start_mult,
  input  wire logic                    start_div,
  output logic                         mdu_busy,
  output logic [c_BUSY_CNT_W-1:0]      busy_cnt
);

  localparam logic [c_BUSY_CNT_W-1:0] c_MULT_LD = MULT_CYC[c_BUSY_CNT_W-1:0];
  localparam logic [c_BUSY_CNT_W-1:0] c_DIV_LD  = DIV_CYC[c_BUSY_CNT_W-1:0];

  logic [0:0]              r_state;
  logic [c_BUSY_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          // Divide wins when both start pulses coincide.
          if (start_div) begin
            r_state <= c_BUSY;
            r_cnt   <= c_DIV_LD;
          end else if (start_mult) begin
            r_state <= c_BUSY;
            r_cnt   <= c_MULT_LD;
          end
        end
        c_BUSY: begin
          if (r_cnt == {{(c_BUSY_CNT_W-1){1'b0}}, 1'b1}) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - {{(c_BUSY_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // The start cycle itself already counts as occupied.
  assign mdu_busy = ~reset & ((r_state == c_BUSY) | start_mult | start_div);
  assign busy_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Tuse/Tnew data-hazard and MDU-occupancy stall control.
//            Optional stall cycle counter: define HAZARD_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = c_DEF_MULT_CYC,
  parameter int DIV_CYC  = c_DEF_DIV_CYC
) (
  input  wire logic    clk,
  input  wire logic    reset,
  hazard_ctrl_if.slave bus
);

  logic w_mdu_busy;
  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_mdu;
  logic w_stall;

  mdu_busy_tracker #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .start_mult (bus.E_start_mult),
    .start_div  (bus.E_start_div),
    .mdu_busy   (w_mdu_busy),
    .busy_cnt   (bus.busy_cnt)
  );

  assign w_stall_rs  = src_hazard(bus.D_rs_addr, bus.D_Tuse_rs, bus.E_wa,
                                  bus.E_Tnew, bus.M_wa, bus.M_Tnew);
  assign w_stall_rt  = src_hazard(bus.D_rt_addr, bus.D_Tuse_rt, bus.E_wa,
                                  bus.E_Tnew, bus.M_wa, bus.M_Tnew);
  assign w_stall_mdu = bus.D_is_mdu & w_mdu_busy;

  // Inputs are don't-care during reset, so the pipeline is held free-running.
  assign w_stall = ~reset & (w_stall_rs | w_stall_rt | w_stall_mdu);

  assign bus.stall    = w_stall;
  assign bus.F_en     = ~w_stall;
  assign bus.FD_en    = ~w_stall;
  assign bus.DE_clr   = w_stall;
  assign bus.mdu_busy = w_mdu_busy;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

`default_nettype wire
